// File: rtl/apcpu_mem_pkg.sv
// Shared definitions for the APCPU ALU <-> data-memory handshake.
// Latency: n/a (constants, types and helpers only).
// Backpressure: n/a.
// Contents: MemIO request codes, responder FSM encoding, data width.
package apcpu_mem_pkg;

   localparam int DATA_W = 32;

   // MemIO request codes driven by the ALU
   localparam logic [1:0] MEM_IDLE  = 2'b00;
   localparam logic [1:0] MEM_READ  = 2'b01;
   localparam logic [1:0] MEM_WRITE = 2'b10;
   localparam logic [1:0] MEM_RSVD  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_ACK  = 2'd2,
      ST_DONE = 2'd3
   } mem_state_e;

   // Only read and write start an access; the reserved code behaves as idle.
   function automatic logic is_req(input logic [1:0] code);
      return (code == MEM_READ) || (code == MEM_WRITE);
   endfunction

endpackage

// File: rtl/apcpu_mem_array.sv
// Single-port synchronous RAM, 2**ADDR_W x DATA_W, no reset.
// Latency: write commits on the clock edge; read data is registered one edge after re_i.
// Backpressure: none; the read register holds its value while re_i is low.
// Ports: clk; we_i write enable; re_i read enable; addr_i word address;
//        wdata_i write data; rdata_o registered read data.
module apcpu_mem_array
   import apcpu_mem_pkg::*;
#(
   parameter int ADDR_W = 10
)
(
   input  logic              clk,
   input  logic              we_i,
   input  logic              re_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [DATA_W-1:0] wdata_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];
   logic [DATA_W-1:0] rdata_q;

   // Contents and read register deliberately have no reset: they survive rst.
   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
         rdata_q <= mem_q[addr_i];
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/apcpu_data_mem.sv
// Data-memory responder for the APCPU ALU handshake, one access at a time.
// Latency: request at edge E0 -> ValidMemData in cycle E0+LATENCY+1; min spacing LATENCY+3.
// Backpressure: Busy high outside IDLE; held requests wait in DONE until MemIO idles.
// Ports: clk, rst (async, active low); MemIO request code; ALUAddr word address;
//        DataIO shared bus (driven here only for read ACK/DONE);
//        ValidMemData one-cycle ack; MemErr out-of-range flag with ack; Busy.
module apcpu_data_mem
   import apcpu_mem_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 2
)
(
   input  logic        clk,
   input  logic        rst,
   input  logic [1:0]  MemIO,
   input  logic [31:0] ALUAddr,
   inout  wire  [31:0] DataIO,
   output logic        ValidMemData,
   output logic        MemErr,
   output logic        Busy
);

   localparam logic [3:0] LAT = 4'(LATENCY);

   mem_state_e        state_q;
   logic [3:0]        cnt_q;
   logic              op_write_q;
   logic              err_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              vld_q;
   logic              err_out_q;
   logic              busy_q;
   logic              oe_q;

   logic              accept;
   logic              req_oor;
   logic              ram_we;
   logic              ram_re;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] rd_word;

   assign accept  = (state_q == ST_IDLE) && is_req(MemIO);
   assign req_oor = |ALUAddr[31:ADDR_W];

   // The RAM sees the live address while idle so the read is launched on the
   // acceptance edge; afterwards it sees the latched address for the write.
   assign ram_addr = (state_q == ST_IDLE) ? ALUAddr[ADDR_W-1:0] : addr_q;
   assign ram_re   = accept && (MemIO == MEM_READ);
   // Write commits on the edge that ends ACK; out-of-range writes are dropped.
   assign ram_we   = (state_q == ST_ACK) && op_write_q && !err_q;

   apcpu_mem_array #(
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk     (clk),
      .we_i    (ram_we),
      .re_i    (ram_re),
      .addr_i  (ram_addr),
      .wdata_i (wdata_q),
      .rdata_o (ram_rdata)
   );

   assign rd_word = err_q ? '0 : ram_rdata;

   // oe_q is a flop with async clear, so the bus is released the moment rst
   // falls and on the same edge the FSM returns to IDLE.
   assign DataIO = oe_q ? rd_word : 'z;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         op_write_q <= 1'b0;
         err_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         vld_q      <= 1'b0;
         err_out_q  <= 1'b0;
         busy_q     <= 1'b0;
         oe_q       <= 1'b0;
      end else begin
         vld_q     <= 1'b0;
         err_out_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  op_write_q <= (MemIO == MEM_WRITE);
                  addr_q     <= ALUAddr[ADDR_W-1:0];
                  err_q      <= req_oor;
                  cnt_q      <= LAT;
                  busy_q     <= 1'b1;
                  if (MemIO == MEM_WRITE) begin
                     wdata_q <= DataIO;
                  end
                  if (LAT == 4'd0) begin
                     state_q   <= ST_ACK;
                     vld_q     <= 1'b1;
                     err_out_q <= req_oor;
                     oe_q      <= (MemIO == MEM_READ);
                  end else begin
                     state_q <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               // WAIT lasts exactly LAT cycles; leave when the count is at 1.
               cnt_q <= cnt_q - 4'd1;
               if (cnt_q == 4'd1) begin
                  state_q   <= ST_ACK;
                  vld_q     <= 1'b1;
                  err_out_q <= err_q;
                  oe_q      <= !op_write_q;
               end
            end
            ST_ACK: begin
               state_q <= ST_DONE;
            end
            ST_DONE: begin
               // A held or switched request code never restarts an access.
               if (!is_req(MemIO)) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
                  oe_q    <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign ValidMemData = vld_q;
   assign MemErr       = err_out_q;
   assign Busy         = busy_q;

endmodule

// File: tb/tb_apcpu_data_mem.sv
// Directed bench for apcpu_data_mem: one instance at LATENCY=2, one at LATENCY=0.
// Both instances share clock, reset, MemIO and ALUAddr; each has its own DataIO bus.
// The bench drives a bus only while that instance's output enable is low.
module tb_apcpu_data_mem;
   import apcpu_mem_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [1:0]  mem_io;
   logic [31:0] alu_addr;
   logic        tb_drv;
   logic [31:0] tb_dat;
   logic        use_l0;
   logic        mon_en;
   int          contend;
   int          n_vec;
   int          n_bad;

   wire [31:0]  bus2;
   wire [31:0]  bus0;
   logic        vld2, err2, busy2;
   logic        vld0, err0, busy0;
   logic        oe2, oe0;

   apcpu_data_mem #(.ADDR_W(10), .LATENCY(2)) u_dut (
      .clk          (clk),
      .rst          (rst_n),
      .MemIO        (mem_io),
      .ALUAddr      (alu_addr),
      .DataIO       (bus2),
      .ValidMemData (vld2),
      .MemErr       (err2),
      .Busy         (busy2)
   );

   apcpu_data_mem #(.ADDR_W(10), .LATENCY(0)) u_dut0 (
      .clk          (clk),
      .rst          (rst_n),
      .MemIO        (mem_io),
      .ALUAddr      (alu_addr),
      .DataIO       (bus0),
      .ValidMemData (vld0),
      .MemErr       (err0),
      .Busy         (busy0)
   );

   assign oe2  = u_dut.oe_q;
   assign oe0  = u_dut0.oe_q;
   assign bus2 = (tb_drv && !oe2) ? tb_dat : 'z;
   assign bus0 = (tb_drv && !oe0) ? tb_dat : 'z;

   logic        cur_vld, cur_err, cur_busy, cur_oe;
   logic [31:0] cur_bus;
   assign cur_vld  = use_l0 ? vld0  : vld2;
   assign cur_err  = use_l0 ? err0  : err2;
   assign cur_busy = use_l0 ? busy0 : busy2;
   assign cur_oe   = use_l0 ? oe0   : oe2;
   assign cur_bus  = use_l0 ? bus0  : bus2;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Both drivers active in the same cycle is a contention event.
   always @(negedge clk) begin
      if (mon_en && tb_drv && (oe2 || oe0)) contend++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk_vec(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Called #1 after a rising edge with the selected instance idle; returns
   // #1 after the edge on which it is back in IDLE.
   task automatic do_req(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdat,
                         output int lat, output logic err,
                         output logic [31:0] rd_ack, output logic [31:0] rd_done);
      mem_io   = op;
      alu_addr = addr;
      tb_dat   = wdat;
      tb_drv   = (op == MEM_WRITE);
      lat      = -1;
      err      = 1'b0;
      rd_ack   = '0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge clk); #1;
         tb_drv = 1'b0;
         if (cur_vld) begin
            lat    = n;
            err    = cur_err;
            rd_ack = cur_bus;
            break;
         end
      end
      @(posedge clk); #1;
      rd_done = cur_bus;
      mem_io  = MEM_IDLE;
      @(posedge clk); #1;
   endtask

   int          lat;
   logic        err;
   logic [31:0] rda, rdd;
   logic [31:0] mdl [8];
   int          pulses, busy_lo, oe_hi;
   logic [31:0] hold_dat;

   initial begin
      n_vec = 0; n_bad = 0; contend = 0; mon_en = 1'b0;
      rst_n = 1'b0; mem_io = MEM_IDLE; alu_addr = '0;
      tb_drv = 1'b0; tb_dat = '0; use_l0 = 1'b0;

      // Reset values
      repeat (3) @(posedge clk);
      #1;
      chk_vec("rst_vld",  32'(vld2),  32'd0);
      chk_vec("rst_err",  32'(err2),  32'd0);
      chk_vec("rst_busy", 32'(busy2), 32'd0);
      chk_vec("rst_oe",   32'(oe2),   32'd0);
      chk_vec("rst_oe0",  32'(oe0),   32'd0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Write then read back at LATENCY=2
      do_req(MEM_WRITE, 32'd5, 32'hDEADBEEF, lat, err, rda, rdd);
      chk_vec("wr5_lat", 32'(lat), 32'd3);
      chk_vec("wr5_err", 32'(err), 32'd0);
      do_req(MEM_READ, 32'd5, 32'h0, lat, err, rda, rdd);
      chk_vec("rd5_lat",  32'(lat), 32'd3);
      chk_vec("rd5_err",  32'(err), 32'd0);
      chk_vec("rd5_ack",  rda, 32'hDEADBEEF);
      chk_vec("rd5_done", rdd, 32'hDEADBEEF);
      chk_vec("rd5_busy_idle", 32'(busy2), 32'd0);
      chk_vec("rd5_oe_idle",   32'(oe2),   32'd0);

      // Held read: one ack only, Busy high until MemIO idles
      do_req(MEM_WRITE, 32'd7, 32'h0000_0777, lat, err, rda, rdd);
      mem_io = MEM_READ; alu_addr = 32'd7;
      pulses = 0; busy_lo = 0; hold_dat = '0;
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         if (vld2) pulses++;
         if (!busy2) busy_lo++;
         if (i == 10) hold_dat = bus2;
      end
      chk_vec("hold_pulses",  32'(pulses),  32'd1);
      chk_vec("hold_busy_lo", 32'(busy_lo), 32'd0);
      chk_vec("hold_data",    hold_dat,     32'h0000_0777);
      mem_io = MEM_IDLE;
      @(posedge clk); #1;
      chk_vec("hold_busy_end", 32'(busy2), 32'd0);

      // Held write switched to read while in DONE: no new access starts
      mem_io = MEM_WRITE; alu_addr = 32'd9; tb_dat = 32'h0000_0099; tb_drv = 1'b1;
      pulses = 0; busy_lo = 0; oe_hi = 0;
      for (int i = 1; i <= 12; i++) begin
         @(posedge clk); #1;
         tb_drv = 1'b0;
         if (i == 6) mem_io = MEM_READ;
         if (vld2) pulses++;
         if (!busy2) busy_lo++;
         if (oe2) oe_hi++;
      end
      chk_vec("sw_pulses",  32'(pulses),  32'd1);
      chk_vec("sw_busy_lo", 32'(busy_lo), 32'd0);
      chk_vec("sw_oe",      32'(oe_hi),   32'd0);
      mem_io = MEM_IDLE;
      @(posedge clk); #1;
      do_req(MEM_READ, 32'd9, 32'h0, lat, err, rda, rdd);
      chk_vec("sw_rd9", rda, 32'h0000_0099);

      // Out-of-range address
      do_req(MEM_WRITE, 32'd0, 32'hA5A5_0000, lat, err, rda, rdd);
      do_req(MEM_READ, 32'h0000_0400, 32'h0, lat, err, rda, rdd);
      chk_vec("oor_rd_lat", 32'(lat), 32'd3);
      chk_vec("oor_rd_err", 32'(err), 32'd1);
      chk_vec("oor_rd_dat", rda, 32'h0);
      do_req(MEM_WRITE, 32'h0000_0400, 32'hFFFF_FFFF, lat, err, rda, rdd);
      chk_vec("oor_wr_err", 32'(err), 32'd1);
      do_req(MEM_READ, 32'd0, 32'h0, lat, err, rda, rdd);
      chk_vec("oor_rd0_err", 32'(err), 32'd0);
      chk_vec("oor_rd0_dat", rda, 32'hA5A5_0000);

      // Reset during WAIT of a write discards it
      do_req(MEM_WRITE, 32'd3, 32'h5555_AAAA, lat, err, rda, rdd);
      mem_io = MEM_WRITE; alu_addr = 32'd3; tb_dat = 32'h0000_1234; tb_drv = 1'b1;
      @(posedge clk); #1;
      tb_drv = 1'b0;
      chk_vec("wait_busy", 32'(busy2), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_vec("arst_vld",  32'(vld2),  32'd0);
      chk_vec("arst_err",  32'(err2),  32'd0);
      chk_vec("arst_busy", 32'(busy2), 32'd0);
      chk_vec("arst_oe",   32'(oe2),   32'd0);
      mem_io = MEM_IDLE;
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      do_req(MEM_READ, 32'd3, 32'h0, lat, err, rda, rdd);
      chk_vec("arst_rd3", rda, 32'h5555_AAAA);

      // Random traffic with scoreboard and bus-contention monitor
      mon_en = 1'b1;
      for (int i = 0; i < 100; i++) begin
         logic [31:0] a;
         logic [31:0] d;
         logic [1:0]  op;
         logic        oor;
         a   = 32'(16 + ((i < 8) ? i : int'($urandom_range(0, 7))));
         oor = (i >= 8) && ($urandom_range(0, 7) == 0);
         if (oor) a = a | 32'h0002_0000;
         op  = ((i < 8) || ($urandom_range(0, 1) == 1)) ? MEM_WRITE : MEM_READ;
         d   = $urandom();
         do_req(op, a, d, lat, err, rda, rdd);
         chk_vec("rnd_lat", 32'(lat), 32'd3);
         chk_vec("rnd_err", 32'(err), 32'(oor));
         if (op == MEM_WRITE) begin
            if (!oor) mdl[a[2:0]] = d;
         end else begin
            chk_vec("rnd_rd", rda, oor ? 32'h0 : mdl[a[2:0]]);
         end
      end
      mon_en = 1'b0;
      chk_vec("contention", 32'(contend), 32'd0);

      // LATENCY=0 back-to-back
      use_l0 = 1'b1;
      do_req(MEM_WRITE, 32'd1, 32'd250, lat, err, rda, rdd);
      chk_vec("l0_wr_lat", 32'(lat), 32'd1);
      do_req(MEM_READ, 32'd1, 32'h0, lat, err, rda, rdd);
      chk_vec("l0_rd_lat",  32'(lat), 32'd1);
      chk_vec("l0_rd_err",  32'(err), 32'd0);
      chk_vec("l0_rd_ack",  rda, 32'd250);
      chk_vec("l0_rd_done", rdd, 32'd250);
      chk_vec("l0_oe_idle", 32'(cur_oe), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
